// File: rtl/regfile_sb.sv
// Two-read / two-write register file with per-register busy scoreboard.
// Port A has priority over port B; optional same-cycle write-to-read bypass.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] wa_a,
    input  logic [DATA_W-1:0] wd_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] wa_b,
    input  logic [DATA_W-1:0] wd_b,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wen_a;
    logic              wen_b;
    logic              wen_b_store;
    logic              iss_ok;

    // Register 0 swallows writes and issue marks when hard-wired to zero.
    assign wen_a       = we_a && !(ZERO_REG != 0 && wa_a == '0);
    assign wen_b       = we_b && !(ZERO_REG != 0 && wa_b == '0);
    assign wen_b_store = wen_b && !(wen_a && wa_a == wa_b);
    assign iss_ok      = iss_en && !(ZERO_REG != 0 && iss_addr == '0);

    // Write-backs clear first so that a same-cycle issue re-marks the register.
    always_comb begin
        busy_nxt = busy;
        if (wen_a) busy_nxt[wa_a] = 1'b0;
        if (wen_b) busy_nxt[wa_b] = 1'b0;
        if (iss_ok) busy_nxt[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wen_b_store) mem[wa_b] <= wd_b;
            if (wen_a) mem[wa_a] <= wd_a;
            busy <= busy_nxt;
        end
    end

    always_comb begin
        rd1   = mem[ra1];
        busy1 = busy[ra1];
        if (ZERO_REG != 0 && ra1 == '0) begin
            rd1   = '0;
            busy1 = 1'b0;
        end
        if (BYPASS != 0) begin
            if (wen_a && wa_a == ra1) begin
                rd1   = wd_a;
                busy1 = 1'b0;
            end else if (wen_b && wa_b == ra1) begin
                rd1   = wd_b;
                busy1 = 1'b0;
            end
        end
    end

    always_comb begin
        rd2   = mem[ra2];
        busy2 = busy[ra2];
        if (ZERO_REG != 0 && ra2 == '0) begin
            rd2   = '0;
            busy2 = 1'b0;
        end
        if (BYPASS != 0) begin
            if (wen_a && wa_a == ra2) begin
                rd2   = wd_a;
                busy2 = 1'b0;
            end else if (wen_b && wa_b == ra2) begin
                rd2   = wd_b;
                busy2 = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (zero-reg+bypass, plain) share stimulus
// and are checked against an array-based reference model.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ra1, ra2, wa_a, wa_b, iss_addr;
    logic [31:0] wd_a, wd_b;
    logic        we_a, we_b, iss_en;

    logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
    logic        busy1_0, busy2_0, busy1_1, busy2_1;

    int n_tests = 0;
    int n_fail  = 0;

    // Model index 0: ZERO_REG=1, BYPASS=1.  Index 1: ZERO_REG=0, BYPASS=0.
    logic [31:0] mm [2][32];
    logic        bm [2][32];

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_0), .rd2(rd2_0),
        .busy1(busy1_0), .busy2(busy2_0), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .iss_en(iss_en), .iss_addr(iss_addr)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut1 (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_1), .rd2(rd2_1),
        .busy1(busy1_1), .busy2(busy2_1), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .iss_en(iss_en), .iss_addr(iss_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic write_ok(input int k, input logic en, input logic [4:0] a);
        return en && !(k == 0 && a == 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input int k, input logic [4:0] a);
        if (k == 0 && a == 5'd0) return 32'd0;
        if (k == 0 && write_ok(k, we_a, wa_a) && wa_a == a) return wd_a;
        if (k == 0 && write_ok(k, we_b, wa_b) && wa_b == a) return wd_b;
        return mm[k][a];
    endfunction

    function automatic logic exp_busy(input int k, input logic [4:0] a);
        if (k == 0 && ((write_ok(k, we_a, wa_a) && wa_a == a) ||
                       (write_ok(k, we_b, wa_b) && wa_b == a))) return 1'b0;
        return bm[k][a];
    endfunction

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < 32; i++) begin
                    mm[k][i] = 32'd0;
                    bm[k][i] = 1'b0;
                end
            end else begin
                // B applied before A so A wins on a shared address.
                if (write_ok(k, we_b, wa_b)) begin mm[k][wa_b] = wd_b; bm[k][wa_b] = 1'b0; end
                if (write_ok(k, we_a, wa_a)) begin mm[k][wa_a] = wd_a; bm[k][wa_a] = 1'b0; end
                if (write_ok(k, iss_en, iss_addr)) bm[k][iss_addr] = 1'b1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_rd1_0"},   rd1_0,            exp_rd(0, ra1));
        check({tag, "_rd2_0"},   rd2_0,            exp_rd(0, ra2));
        check({tag, "_busy1_0"}, {31'd0, busy1_0}, {31'd0, exp_busy(0, ra1)});
        check({tag, "_busy2_0"}, {31'd0, busy2_0}, {31'd0, exp_busy(0, ra2)});
        check({tag, "_rd1_1"},   rd1_1,            exp_rd(1, ra1));
        check({tag, "_rd2_1"},   rd2_1,            exp_rd(1, ra2));
        check({tag, "_busy1_1"}, {31'd0, busy1_1}, {31'd0, exp_busy(1, ra1)});
        check({tag, "_busy2_1"}, {31'd0, busy2_1}, {31'd0, exp_busy(1, ra2)});
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; we_a = 1'b0; we_b = 1'b0; iss_en = 1'b0;
        wa_a = 5'd0; wa_b = 5'd0; wd_a = 32'd0; wd_b = 32'd0; iss_addr = 5'd0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) begin mm[k][i] = 32'd0; bm[k][i] = 1'b0; end
        idle();
        ra1 = 5'd0; ra2 = 5'd0;
        reset = 1'b1;
        tick();

        // T1: populate, then reset with a write pending in the reset cycle
        for (int i = 1; i < 6; i++) begin
            idle();
            we_a = 1'b1; wa_a = 5'(i); wd_a = $urandom;
            we_b = 1'b1; wa_b = 5'(i + 10); wd_b = $urandom;
            iss_en = 1'b1; iss_addr = 5'(i + 20);
            ra1 = 5'(i); ra2 = 5'(i + 20);
            #2 compare_all("t1_fill");
            tick();
        end
        idle();
        reset = 1'b1; we_a = 1'b1; wa_a = 5'd4; wd_a = 32'h1234_5678;
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            #2;
            check("t1_rd1_zero", rd1_0, 32'd0);
            check("t1_rd2_zero", rd2_1, 32'd0);
            check("t1_busy1_zero", {31'd0, busy1_0}, 32'd0);
            check("t1_busy2_zero", {31'd0, busy2_1}, 32'd0);
            tick();
        end

        // T2: bypass versus registered read
        idle();
        we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEAD_BEEF; ra1 = 5'd5; ra2 = 5'd6;
        #2;
        check("t2_bypass", rd1_0, 32'hDEAD_BEEF);
        check("t2_nobypass_old", rd1_1, 32'd0);
        tick();
        idle();
        #2;
        check("t2_nobypass_new", rd1_1, 32'hDEAD_BEEF);
        check("t2_bypass_stored", rd1_0, 32'hDEAD_BEEF);
        tick();

        // T3: both ports to the same address
        idle();
        we_a = 1'b1; we_b = 1'b1; wa_a = 5'd7; wa_b = 5'd7; wd_a = 32'd1; wd_b = 32'd2;
        ra1 = 5'd7; ra2 = 5'd7;
        #2;
        check("t3_same_cycle", rd1_0, 32'd1);
        tick();
        idle();
        #2;
        check("t3_stored_0", rd2_0, 32'd1);
        check("t3_stored_1", rd2_1, 32'd1);
        tick();

        // T4: register 0
        idle();
        we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFF_FFFF; iss_en = 1'b1; iss_addr = 5'd0;
        ra1 = 5'd0; ra2 = 5'd0;
        #2;
        check("t4_rd0", rd1_0, 32'd0);
        check("t4_busy0", {31'd0, busy2_0}, 32'd0);
        compare_all("t4_cyc0");
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            #2;
            check("t4_rd0_later", rd1_0, 32'd0);
            check("t4_busy0_later", {31'd0, busy1_0}, 32'd0);
            check("t4_r0_nozero", rd1_1, 32'hFFFF_FFFF);
            check("t4_b0_nozero", {31'd0, busy1_1}, 32'd1);
            tick();
        end

        // T5: issue then write-back through port B
        idle();
        iss_en = 1'b1; iss_addr = 5'd9; ra1 = 5'd9;
        #2 compare_all("t5_issue");
        tick();
        idle();
        #2;
        check("t5_busy_set", {31'd0, busy1_0}, 32'd1);
        tick();
        we_b = 1'b1; wa_b = 5'd9; wd_b = 32'd42;
        #2;
        check("t5_busy_bypass", {31'd0, busy1_0}, 32'd0);
        check("t5_rd_bypass", rd1_0, 32'd42);
        check("t5_busy_nobyp", {31'd0, busy1_1}, 32'd1);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            #2;
            check("t5_busy_clear", {31'd0, busy1_0}, 32'd0);
            check("t5_rd_after", rd1_1, 32'd42);
            tick();
        end

        // T6: issue colliding with write, then reset clears busy
        idle();
        iss_en = 1'b1; iss_addr = 5'd3; we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h33; ra1 = 5'd3;
        #2;
        check("t6_same_cycle_busy", {31'd0, busy1_0}, 32'd0);
        tick();
        idle();
        #2;
        check("t6_busy_set", {31'd0, busy1_0}, 32'd1);
        check("t6_data", rd1_0, 32'h33);
        check("t6_busy_set_1", {31'd0, busy1_1}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        idle();
        #2;
        check("t6_busy_reset", {31'd0, busy1_0}, 32'd0);
        check("t6_data_reset", rd1_0, 32'd0);
        tick();

        // Randomized traffic, biased toward a few addresses to provoke collisions
        for (int n = 0; n < 400; n++) begin
            logic narrow;
            narrow   = $urandom_range(0, 1) == 1;
            reset    = $urandom_range(0, 63) == 0;
            we_a     = $urandom_range(0, 1) == 1;
            we_b     = $urandom_range(0, 1) == 1;
            iss_en   = $urandom_range(0, 2) != 0;
            wa_a     = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wa_b     = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            iss_addr = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            ra1      = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            ra2      = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wd_a     = $urandom;
            wd_b     = $urandom;
            #2;
            if (!reset) compare_all("rand");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
